jx2_ex_alu_wide_seq: RTL and testbench
======================================

// Module: jx2_ex_alu_wide_seq
// PURPOSE
//  Two-beat sequencer running 128-bit ADD/SUB/ADC/SBB (or one-beat 64-bit) through the
//  EX-stage 64-bit carry-select add/sub unit. Drives that unit's Rm/Ri operands,
//  selects among its precomputed cin=0/cin=1 33-bit half results, chains carry between
//  beats, and returns the result over a valid/ready handshake. Sits beside the EX ALU.
// PARAMETERS
//  (none; widths fixed: 64-bit beat, 128-bit operation)
// PORTS
//  clock        in   1    core clock; all state changes on rising edge
//  reset        in   1    synchronous, active-high
//  opValid      in   1    request valid
//  opReady      out  1    block idle; request accepted when opValid&&opReady
//  opSub        in   1    0=add (uses add ports), 1=sub (uses sub ports)
//  opWide       in   1    1=128-bit (two beats), 0=64-bit (one beat)
//  opCin        in   1    raw adder carry-in: ADD=0, SUB=1, ADC/SBB=flag
//  opValA       in   128  Rm operand (64-bit mode uses [63:0])
//  opValB       in   128  Ri operand (64-bit mode uses [63:0])
//  aluValRm     out  64   operand to ALU Rm port
//  aluValRi     out  64   operand to ALU Ri port
//  aluAddA0/A1  in   33   ALU low-32 add result, cin 0/1 ([32]=carry)
//  aluAddB0/B1  in   33   ALU high-32 add result, cin 0/1
//  aluSubA0/A1  in   33   ALU low-32 sub result (Rm+~Ri+cin), cin 0/1
//  aluSubB0/B1  in   33   ALU high-32 sub result, cin 0/1
//  resValid     out  1    result valid, one-cycle pulse
//  resVal       out  128  result; 64-bit mode: [127:64]=0
//  resCout      out  1    raw adder carry-out of the final beat
// BEHAVIOUR
//  - FSM: IDLE -> LO -> (opWide ? HI : DONE); HI -> DONE; DONE -> IDLE.
//  - IDLE: opReady=1; on accept latch op*, cin register <= opCin, go LO.
//  - LO: drive opValA[63:0]/opValB[63:0]; HI: drive [127:64]; IDLE/DONE: drive 0.
//  - Per beat with carry c, set X = opSub ? Sub : Add:
//    lo = c ? X_A1 : X_A0; hi = lo[32] ? X_B1 : X_B0; beat = {hi[31:0],lo[31:0]};
//    cout = hi[32]. ALU is combinational: capture in the same cycle.
//  - LO: resVal[63:0] <= beat; cin reg <= cout. HI: resVal[127:64] <= beat.
//  - Final beat's cout -> resCout. DONE: resValid=1 exactly one cycle.
//  - Latency: accept at edge N -> resValid high cycle N+3 (wide), N+2 (narrow).
//  - Throughput: next accept earliest in cycle after DONE; opReady=0 in LO/HI/DONE.
//  - resVal/resCout hold until next accept, then clear to 0 at acceptance.
//  - opValid while busy: ignored, not queued; op* may change freely after accept.
//  - Wrap: all-ones + 1 wraps to 0, resCout=1; no saturation.
//  - Reset (incl. mid-op): state IDLE, opReady=1, resValid=0, resVal=0, resCout=0,
//    aluValRm/Ri=0, flags=0; in-flight op discarded, no resValid.
// CONFIGURATION
//  JX2_ALU_WIDESEQ_FLAGS_EN defined: adds outputs resZero (1; resVal of active
//  width ==0) and resOvf (1; signed overflow of final beat: sign-in A==sign-in
//  (B^opSub) && sign-out!=sign-in A); valid with resValid, held, reset 0.
//  Undefined: ports absent, no flag logic.
// TESTING
//  - Wide ADD A=0x0000..0000_FFFFFFFFFFFFFFFF, B=1, cin 0 ->
//    resVal=0x1_0000000000000000, resCout=0, resValid at N+3.
//  - Wide SUB A=0, B=1, cin 1 -> resVal=all-ones 128b, resCout=0 (borrow);
//    flags build: resZero=0, resOvf=0.
//  - Narrow ADC A=0xFFFFFFFFFFFFFFFF, B=0, cin 1 -> resVal=0, resCout=1, resValid at N+2;
//    flags: resZero=1.
//  - Flags: wide ADD A=0x7FFF..FF, B=1 -> resVal=0x8000..00, resOvf=1.
//  - opValid held high continuously: accepts spaced 4 cycles apart (wide); second
//    request's operands sampled only at its accept.
//  - reset asserted in HI cycle -> next cycle IDLE, opReady=1, resVal=0, no resValid.

Source files
------------

// File: rtl/jx2_ex_alu_wide_seq.sv
// Two-beat 128-bit (or one-beat 64-bit) ADD/SUB/ADC/SBB sequencer around the EX carry-select adder.
// Optional flag outputs resZero/resOvf are enabled with `define JX2_ALU_WIDESEQ_FLAGS_EN.
module jx2_ex_alu_wide_seq (
    input  logic         clock,
    input  logic         reset,
    input  logic         opValid,
    output logic         opReady,
    input  logic         opSub,
    input  logic         opWide,
    input  logic         opCin,
    input  logic [127:0] opValA,
    input  logic [127:0] opValB,
    output logic [63:0]  aluValRm,
    output logic [63:0]  aluValRi,
    input  logic [32:0]  aluAddA0,
    input  logic [32:0]  aluAddA1,
    input  logic [32:0]  aluAddB0,
    input  logic [32:0]  aluAddB1,
    input  logic [32:0]  aluSubA0,
    input  logic [32:0]  aluSubA1,
    input  logic [32:0]  aluSubB0,
    input  logic [32:0]  aluSubB1,
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
    output logic         resZero,
    output logic         resOvf,
`endif
    output logic         resValid,
    output logic [127:0] resVal,
    output logic         resCout
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} seqState_t;

    // Low halves go straight to the ALU operand registers at accept; only the high halves are kept.
    typedef struct packed {
        logic        sub;
        logic        wide;
        logic [63:0] aHi;
        logic [63:0] bHi;
    } wideReq_t;

    seqState_t   state;
    wideReq_t    req;
    logic        cinReg;
    logic [32:0] loSel;
    logic [32:0] hiSel;
    logic [63:0] beat;
    logic        beatCout;

    // Carry-select: beat carry picks the low half, low half's carry picks the high half.
    always_comb begin
        loSel = '0;
        hiSel = '0;
        if (req.sub) begin
            loSel = cinReg   ? aluSubA1 : aluSubA0;
            hiSel = loSel[32] ? aluSubB1 : aluSubB0;
        end else begin
            loSel = cinReg   ? aluAddA1 : aluAddA0;
            hiSel = loSel[32] ? aluAddB1 : aluAddB0;
        end
        beat     = {hiSel[31:0], loSel[31:0]};
        beatCout = hiSel[32];
    end

`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
    logic beatOvf;
    assign beatOvf = (aluValRm[63] == (aluValRi[63] ^ req.sub)) && (beat[63] != aluValRm[63]);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            req      <= '0;
            cinReg   <= 1'b0;
            opReady  <= 1'b1;
            resValid <= 1'b0;
            resVal   <= '0;
            resCout  <= 1'b0;
            aluValRm <= '0;
            aluValRi <= '0;
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
            resZero  <= 1'b0;
            resOvf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (opValid) begin
                        req      <= '{sub: opSub, wide: opWide, aHi: opValA[127:64], bHi: opValB[127:64]};
                        cinReg   <= opCin;
                        aluValRm <= opValA[63:0];
                        aluValRi <= opValB[63:0];
                        resVal   <= '0;
                        resCout  <= 1'b0;
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
                        resZero  <= 1'b0;
                        resOvf   <= 1'b0;
`endif
                        opReady  <= 1'b0;
                        state    <= LO;
                    end
                end
                LO: begin
                    resVal[63:0] <= beat;
                    cinReg       <= beatCout;
                    if (req.wide) begin
                        aluValRm <= req.aHi;
                        aluValRi <= req.bHi;
                        state    <= HI;
                    end else begin
                        aluValRm <= '0;
                        aluValRi <= '0;
                        resCout  <= beatCout;
                        resValid <= 1'b1;
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
                        resZero  <= (beat == 64'd0);
                        resOvf   <= beatOvf;
`endif
                        state    <= DONE;
                    end
                end
                HI: begin
                    resVal[127:64] <= beat;
                    resCout        <= beatCout;
                    aluValRm       <= '0;
                    aluValRi       <= '0;
                    resValid       <= 1'b1;
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
                    resZero        <= (resVal[63:0] == 64'd0) && (beat == 64'd0);
                    resOvf         <= beatOvf;
`endif
                    state          <= DONE;
                end
                default: begin
                    resValid <= 1'b0;
                    opReady  <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jx2_ex_alu_wide_seq.sv
// Bench for jx2_ex_alu_wide_seq: combinational carry-select ALU model plus plain-arithmetic reference.
module tb_jx2_ex_alu_wide_seq;

    logic         clock = 1'b0;
    logic         reset;
    logic         opValid, opReady, opSub, opWide, opCin;
    logic [127:0] opValA, opValB;
    logic [63:0]  aluValRm, aluValRi;
    logic [32:0]  aluAddA0, aluAddA1, aluAddB0, aluAddB1;
    logic [32:0]  aluSubA0, aluSubA1, aluSubB0, aluSubB1;
    logic         resValid, resCout;
    logic [127:0] resVal;
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
    logic         resZero, resOvf;
`endif

    int nCmp  = 0;
    int nFail = 0;

    always #5 clock = ~clock;

    jx2_ex_alu_wide_seq dut (
        .clock(clock), .reset(reset),
        .opValid(opValid), .opReady(opReady), .opSub(opSub), .opWide(opWide), .opCin(opCin),
        .opValA(opValA), .opValB(opValB), .aluValRm(aluValRm), .aluValRi(aluValRi),
        .aluAddA0(aluAddA0), .aluAddA1(aluAddA1), .aluAddB0(aluAddB0), .aluAddB1(aluAddB1),
        .aluSubA0(aluSubA0), .aluSubA1(aluSubA1), .aluSubB0(aluSubB0), .aluSubB1(aluSubB1),
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
        .resZero(resZero), .resOvf(resOvf),
`endif
        .resValid(resValid), .resVal(resVal), .resCout(resCout)
    );

    // EX-stage adder halves: independent 32-bit sums for both carry-in values.
    always_comb begin
        aluAddA0 = {1'b0, aluValRm[31:0]}  + {1'b0, aluValRi[31:0]};
        aluAddA1 = {1'b0, aluValRm[31:0]}  + {1'b0, aluValRi[31:0]}  + 33'd1;
        aluAddB0 = {1'b0, aluValRm[63:32]} + {1'b0, aluValRi[63:32]};
        aluAddB1 = {1'b0, aluValRm[63:32]} + {1'b0, aluValRi[63:32]} + 33'd1;
        aluSubA0 = {1'b0, aluValRm[31:0]}  + {1'b0, ~aluValRi[31:0]};
        aluSubA1 = {1'b0, aluValRm[31:0]}  + {1'b0, ~aluValRi[31:0]}  + 33'd1;
        aluSubB0 = {1'b0, aluValRm[63:32]} + {1'b0, ~aluValRi[63:32]};
        aluSubB1 = {1'b0, aluValRm[63:32]} + {1'b0, ~aluValRi[63:32]} + 33'd1;
    end

    // Reference: {carry, value} of A + (sub ? ~B : B) + cin at the active width.
    function automatic logic [128:0] refOp(input logic s, input logic w, input logic c,
                                           input logic [127:0] a, input logic [127:0] b);
        logic [127:0] bb;
        logic [64:0]  n;
        bb = s ? ~b : b;
        n  = {1'b0, a[63:0]} + {1'b0, bb[63:0]} + 65'(c);
        if (w) return {1'b0, a} + {1'b0, bb} + 129'(c);
        return {n[64], 64'd0, n[63:0]};
    endfunction

    function automatic logic refOvf(input logic s, input logic w, input logic c,
                                    input logic [127:0] a, input logic [127:0] b);
        logic [128:0] r;
        logic sa, sb, so;
        r  = refOp(s, w, c, a, b);
        sa = w ? a[127] : a[63];
        sb = (w ? b[127] : b[63]) ^ s;
        so = w ? r[127] : r[63];
        return (sa == sb) && (so != sa);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble();
        opSub  = 1'($urandom);
        opWide = 1'($urandom);
        opCin  = 1'($urandom);
        opValA = rnd128();
        opValB = rnd128();
    endtask

    task automatic waitResult(input string tag, input int expLat, input logic [128:0] exp,
                              input logic expOvf, input logic w);
        int lat;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resValid && lat < 8);
        check({tag, "_lat"}, 128'(lat), 128'(expLat));
        check({tag, "_val"}, resVal, exp[127:0]);
        check({tag, "_cout"}, 128'(resCout), 128'(exp[128]));
`ifdef JX2_ALU_WIDESEQ_FLAGS_EN
        check({tag, "_zero"}, 128'(resZero), 128'(exp[127:0] == 128'd0));
        check({tag, "_ovf"}, 128'(resOvf), 128'(expOvf));
`else
        if (expOvf && w) lat = lat;
`endif
        @(negedge clock);
        check({tag, "_vldpulse"}, 128'(resValid), 128'(0));
        check({tag, "_hold"}, resVal, exp[127:0]);
    endtask

    task automatic runOp(input logic s, input logic w, input logic c,
                         input logic [127:0] a, input logic [127:0] b, input string tag);
        logic [128:0] exp;
        logic         ovf;
        exp = refOp(s, w, c, a, b);
        ovf = refOvf(s, w, c, a, b);
        @(negedge clock);
        check({tag, "_rdy"}, 128'(opReady), 128'(1));
        opValid = 1'b1; opSub = s; opWide = w; opCin = c; opValA = a; opValB = b;
        @(posedge clock); #1;
        opValid = 1'b0;
        scramble();
        check({tag, "_rm"}, 128'(aluValRm), 128'(a[63:0]));
        waitResult(tag, w ? 3 : 2, exp, ovf, w);
    endtask

    initial begin
        logic [128:0] exp1, exp2;
        logic         ovf1, ovf2, sawValid;
        logic [127:0] a1, b1, a2, b2;

        reset = 1'b1; opValid = 1'b0; opSub = 1'b0; opWide = 1'b0; opCin = 1'b0;
        opValA = '0; opValB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rdy",   128'(opReady),  128'(1));
        check("rst_vld",   128'(resValid), 128'(0));
        check("rst_val",   resVal,         128'd0);
        check("rst_cout",  128'(resCout),  128'(0));
        check("rst_rm",    128'(aluValRm), 128'd0);
        reset = 1'b0;

        // Directed corner cases
        runOp(1'b0, 1'b1, 1'b0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd1, "wadd");
        runOp(1'b1, 1'b1, 1'b1, 128'd0, 128'd1, "wsub");
        runOp(1'b0, 1'b0, 1'b1, {64'hDEAD_BEEF_0000_1111, 64'hFFFF_FFFF_FFFF_FFFF}, 128'd0, "nadc");
        runOp(1'b0, 1'b1, 1'b0, {1'b0, {127{1'b1}}}, 128'd1, "wovf");
        runOp(1'b0, 1'b1, 1'b0, {128{1'b1}}, 128'd1, "wwrap");
        runOp(1'b1, 1'b0, 1'b1, 128'h8000_0000_0000_0000, 128'd1, "nsubovf");
        runOp(1'b1, 1'b1, 1'b0, 128'd5, 128'd5, "wsbb");

        // Randomized ops, with operand upper halves left as garbage in narrow mode
        for (int i = 0; i < 40; i++) begin
            runOp(1'($urandom), 1'($urandom), 1'($urandom),
                  (i % 8 == 0) ? {128{1'b1}} : rnd128(), rnd128(), "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // opValid held high: second op must wait for DONE and use operands present at its accept
        a1 = rnd128(); b1 = rnd128(); a2 = rnd128(); b2 = rnd128();
        exp1 = refOp(1'b0, 1'b1, 1'b0, a1, b1); ovf1 = refOvf(1'b0, 1'b1, 1'b0, a1, b1);
        exp2 = refOp(1'b1, 1'b1, 1'b1, a2, b2); ovf2 = refOvf(1'b1, 1'b1, 1'b1, a2, b2);
        @(negedge clock);
        opValid = 1'b1; opSub = 1'b0; opWide = 1'b1; opCin = 1'b0; opValA = a1; opValB = b1;
        @(posedge clock); #1;
        opSub = 1'b1; opCin = 1'b1; opValA = a2; opValB = b2;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            check("b2b_busy", 128'(opReady), 128'(0));
        end
        check("b2b_vld1", 128'(resValid), 128'(1));
        check("b2b_val1", resVal, exp1[127:0]);
        check("b2b_cout1", 128'(resCout), 128'(exp1[128]));
        @(negedge clock);
        check("b2b_rdy", 128'(opReady), 128'(1));
        @(posedge clock); #1;
        opValid = 1'b0;
        check("b2b_clr", resVal, 128'd0);
        scramble();
        waitResult("b2b2", 3, exp2, ovf2, 1'b1);
        if (ovf1) ovf1 = 1'b0;

        // Reset during the HI beat discards the op
        @(negedge clock);
        opValid = 1'b1; opSub = 1'b0; opWide = 1'b1; opCin = 1'b0; opValA = rnd128(); opValB = rnd128();
        @(posedge clock); #1;
        opValid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_rdy",  128'(opReady),  128'(1));
        check("midrst_vld",  128'(resValid), 128'(0));
        check("midrst_val",  resVal,         128'd0);
        check("midrst_cout", 128'(resCout),  128'(0));
        check("midrst_rm",   128'(aluValRm), 128'd0);
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (5) begin
            @(negedge clock);
            sawValid = sawValid | resValid;
        end
        check("midrst_novld", 128'(sawValid), 128'(0));
        runOp(1'b0, 1'b1, 1'b1, 128'd7, 128'd9, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
